dram_controller: RTL and testbench

DRAM_CONTROLLER -- requirements
Module: dram_controller

---
 rtl/dram_pkg.sv | 40 ++++
 rtl/dram_refresh_timer.sv | 40 ++++
 rtl/dram_controller.sv | 218 +++++++++++++++++++++
 tb/tb_dram_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared state encoding and CPU-address field layout for the DRAM controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package dram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RAS_ON,
    RCD_WAIT,
    ACCESS,
    PRECHARGE,
    REF_CAS,
    REF_RAS,
    REF_HOLD,
    PAGE_OPEN
  } state_t;

  // Column starts above the 32-bit word's byte offset; row sits above column,
  // bank select above row.
  localparam int COL_LSB = 2;
  localparam logic [3:0] CAS_ALL = 4'b1111;

  function automatic int row_lsb(input int col_bits);
    return COL_LSB + col_bits;
  endfunction

  function automatic int bank_lsb(input int row_bits, input int col_bits);
    return COL_LSB + col_bits + row_bits;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A single-bank part still needs a 1-bit field so widths stay legal.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter plus saturating backlog count.
// Latency: pending rises on the edge the interval counter wraps; falls on the edge i_ref_done is seen.
// Backpressure: backlog saturates at MAX_PENDING; a wrap and a done on the same edge cancel.
// Ports: clock, reset_n (sync, active-low); i_ref_done = one refresh sequence finished;
//        o_pending = outstanding refresh requests.
module dram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 250,
  parameter int MAX_PENDING      = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               i_ref_done,
  output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pending;
  logic          w_wrap;

  assign w_wrap    = (r_cnt == CW'(REFRESH_INTERVAL - 1));
  assign o_pending = r_pending;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_pending <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      case ({w_wrap, i_ref_done})
        2'b10: if (r_pending != PW'(MAX_PENDING)) r_pending <= r_pending + PW'(1);
        2'b01: if (r_pending != '0) r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

endmodule

// File: rtl/dram_controller.sv
// dram_controller: single-port CPU-to-DRAM controller with CAS-before-RAS refresh arbitration.
// Latency: ras/row one edge after cs&&ds is sampled, cas and waitstate=0 T_RCD edges after ras.
// Backpressure: waitstate=1 holds the CPU until cas; a pending refresh wins over a new access in IDLE.
// Ports: clock, reset_n (sync, active-low); cs/ds/rn_w/addr/byte_selects from the CPU;
//        write/ras/cas/dram_addr to the DRAM; waitstate back to the CPU.
// Option: define DRAM_PAGE_MODE_EN to keep the row open between accesses (fast page mode).
module dram_controller
  import dram_pkg::*;
#(
  parameter int NUM_BANKS        = 2,
  parameter int ROW_BITS         = 11,
  parameter int COL_BITS         = 11,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int REFRESH_INTERVAL = 250,
  parameter int MAX_PENDING      = 4
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  cs,
  input  logic                                  ds,
  input  logic                                  rn_w,
  input  logic [31:0]                           addr,
  input  logic [3:0]                            byte_selects,
  output logic                                  write,
  output logic [NUM_BANKS-1:0]                  ras,
  output logic [3:0]                            cas,
  output logic [max2(ROW_BITS,COL_BITS)-1:0]    dram_addr,
  output logic                                  waitstate
);

  localparam int AW     = max2(ROW_BITS, COL_BITS);
  localparam int BW     = bank_w(NUM_BANKS);
  localparam int ROW_LO = row_lsb(COL_BITS);
  localparam int BANK_LO = bank_lsb(ROW_BITS, COL_BITS);
  localparam int CNT_W  = $clog2(max2(T_RCD, T_RP) + 1);
  localparam int PW     = $clog2(MAX_PENDING + 1);

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

  // Request fields captured at access start (and on a page hit).
  logic [BW-1:0]          r_bank;
  logic [ROW_BITS-1:0]    r_row;
  logic [COL_BITS-1:0]    r_col;
  logic                   r_wr;
  logic [3:0]             r_be;

  logic                   r_write, w_write_nxt;
  logic [NUM_BANKS-1:0]   r_ras, w_ras_nxt;
  logic [3:0]             r_cas, w_cas_nxt;
  logic [AW-1:0]          r_dram_addr, w_dram_addr_nxt;
  logic                   r_waitstate, w_waitstate_nxt;

  logic [COL_BITS-1:0]    w_col_in;
  logic [ROW_BITS-1:0]    w_row_in;
  logic [BW-1:0]          w_bank_in;
  logic                   w_req, w_ref_due, w_ref_done, w_load, w_hit;
  logic [PW-1:0]          w_pending;
  logic [BW-1:0]          w_lat_bank;
  logic [ROW_BITS-1:0]    w_lat_row;
  logic [COL_BITS-1:0]    w_lat_col;
  logic                   w_lat_wr;
  logic [3:0]             w_lat_be;
  logic [NUM_BANKS-1:0]   w_ras_bank;
  logic                   w_unused;

  assign w_col_in  = addr[COL_LSB +: COL_BITS];
  assign w_row_in  = addr[ROW_LO +: ROW_BITS];
  assign w_bank_in = (NUM_BANKS > 1) ? addr[BANK_LO +: BW] : '0;
  assign w_unused  = ^{addr[31:BANK_LO+BW], addr[COL_LSB-1:0]};

  assign w_req      = cs && ds;
  assign w_ref_due  = (w_pending != '0);
  assign w_ref_done = (r_state == REF_HOLD);
  assign w_hit      = (w_bank_in == r_bank) && (w_row_in == r_row);

  // Capture on the edge that starts an access, so the output logic can use
  // the live CPU fields on that edge and the held copy afterwards.
  assign w_load = ((r_state == IDLE) && (w_state_nxt == RAS_ON)) ||
                  ((r_state == PAGE_OPEN) && (w_state_nxt == ACCESS));

  assign w_lat_bank = w_load ? w_bank_in    : r_bank;
  assign w_lat_row  = w_load ? w_row_in     : r_row;
  assign w_lat_col  = w_load ? w_col_in     : r_col;
  assign w_lat_wr   = w_load ? ~rn_w        : r_wr;
  assign w_lat_be   = w_load ? byte_selects : r_be;
  assign w_ras_bank = NUM_BANKS'(1) << w_lat_bank;

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING)
  ) u_refresh_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_ref_done (w_ref_done),
    .o_pending  (w_pending)
  );

  // State register (outputs are registered alongside so they change with the state).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_wr        <= 1'b0;
      r_be        <= '0;
      r_write     <= 1'b0;
      r_ras       <= '0;
      r_cas       <= '0;
      r_dram_addr <= '0;
      r_waitstate <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_bank <= w_bank_in;
        r_row  <= w_row_in;
        r_col  <= w_col_in;
        r_wr   <= ~rn_w;
        r_be   <= byte_selects;
      end
      r_write     <= w_write_nxt;
      r_ras       <= w_ras_nxt;
      r_cas       <= w_cas_nxt;
      r_dram_addr <= w_dram_addr_nxt;
      r_waitstate <= w_waitstate_nxt;
    end
  end

  // Next-state and wait counter. RCD_WAIT lasts T_RCD-1 cycles so cas lands
  // T_RCD edges after ras; PRECHARGE lasts T_RP cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ref_due)  w_state_nxt = REF_CAS;
        else if (w_req) w_state_nxt = RAS_ON;
      end
      RAS_ON:    w_state_nxt = RCD_WAIT;
      RCD_WAIT:  if (r_cnt == '0) w_state_nxt = ACCESS;
      ACCESS: begin
        if (!cs) begin
`ifdef DRAM_PAGE_MODE_EN
          w_state_nxt = PAGE_OPEN;
`else
          w_state_nxt = PRECHARGE;
`endif
        end
      end
      PRECHARGE: if (r_cnt == '0) w_state_nxt = IDLE;
      REF_CAS:   w_state_nxt = REF_RAS;
      REF_RAS:   w_state_nxt = REF_HOLD;
      REF_HOLD:  w_state_nxt = PRECHARGE;
      PAGE_OPEN: begin
`ifdef DRAM_PAGE_MODE_EN
        if (w_ref_due)  w_state_nxt = PRECHARGE;
        else if (w_req) w_state_nxt = w_hit ? ACCESS : PRECHARGE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default:   w_state_nxt = IDLE;
    endcase

    w_cnt_nxt = r_cnt;
    if ((w_state_nxt == RCD_WAIT) && (r_state != RCD_WAIT))
      w_cnt_nxt = CNT_W'(T_RCD - 2);
    else if ((w_state_nxt == PRECHARGE) && (r_state != PRECHARGE))
      w_cnt_nxt = CNT_W'(T_RP - 1);
    else if (r_cnt != '0)
      w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  // Output values for the state being entered.
  always_comb begin
    w_write_nxt     = 1'b0;
    w_ras_nxt       = '0;
    w_cas_nxt       = '0;
    w_waitstate_nxt = 1'b1;
    w_dram_addr_nxt = r_dram_addr;
    case (w_state_nxt)
      RAS_ON: begin
        w_ras_nxt       = w_ras_bank;
        w_write_nxt     = w_lat_wr;
        w_dram_addr_nxt = AW'(w_lat_row);
      end
      RCD_WAIT: begin
        w_ras_nxt       = w_ras_bank;
        w_write_nxt     = w_lat_wr;
        w_dram_addr_nxt = AW'(w_lat_col);
      end
      ACCESS: begin
        w_ras_nxt       = w_ras_bank;
        w_write_nxt     = w_lat_wr;
        w_dram_addr_nxt = AW'(w_lat_col);
        w_cas_nxt       = w_lat_wr ? w_lat_be : CAS_ALL;
        w_waitstate_nxt = 1'b0;
      end
      PAGE_OPEN: w_ras_nxt = w_ras_bank;
      REF_CAS:   w_cas_nxt = CAS_ALL;
      REF_RAS, REF_HOLD: begin
        w_cas_nxt = CAS_ALL;
        w_ras_nxt = '1;
      end
      default: ;
    endcase
  end

  assign write     = r_write;
  assign ras       = r_ras;
  assign cas       = r_cas;
  assign dram_addr = r_dram_addr;
  assign waitstate = r_waitstate;

endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller: directed stimulus for dram_controller with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Covers reset, read/write timing, precharge length, refresh cadence, backlog and reset abort.
module tb_dram_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cs, ds, rn_w;
  logic [31:0] addr;
  logic [3:0]  byte_selects;
  logic        write;
  logic [1:0]  ras;
  logic [3:0]  cas;
  logic [10:0] dram_addr;
  logic        waitstate;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DRAM_PAGE_MODE_EN
  localparam int PG = 1;
`else
  localparam int PG = 0;
`endif

  dram_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cs           (cs),
    .ds           (ds),
    .rn_w         (rn_w),
    .addr         (addr),
    .byte_selects (byte_selects),
    .write        (write),
    .ras          (ras),
    .cas          (cas),
    .dram_addr    (dram_addr),
    .waitstate    (waitstate)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    cs = 1'b0; ds = 1'b0; rn_w = 1'b1; addr = 32'h0; byte_selects = 4'h0;
  endtask

  task automatic req(input logic [31:0] a, input logic rd, input logic [3:0] be);
    cs = 1'b1; ds = 1'b1; addr = a; rn_w = rd; byte_selects = be;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int nref, first, first_acc, bad_order, hi, found;
  logic [1:0] prev_ras;
  logic [3:0] prev_cas;

  initial begin
    idle_bus();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_write", write, 0);
    chk("rst_ras", ras, 0);
    chk("rst_cas", cas, 0);
    chk("rst_addr", dram_addr, 0);
    chk("rst_ws", waitstate, 1);
    chk("rst_pending", dut.w_pending, 0);
    reset_n = 1'b1;

`ifdef DRAM_PAGE_MODE_EN
    // Page mode: same-row hit reuses the open row, a different row precharges.
    req(32'h0000_1004, 1'b1, 4'h0);
    tick(); tick(); tick();
    chk("pg_cas1", cas, 4'hf);
    idle_bus(); tick();
    chk("pg_open", {ras, cas, waitstate}, {2'b01, 4'h0, 1'b1});
    req(32'h0000_1008, 1'b1, 4'h0); tick();
    chk("pg_hit", {ras, cas, waitstate}, {2'b01, 4'hf, 1'b0});
    chk("pg_hit_col", dram_addr, 11'h402);
    idle_bus(); tick();
    req(32'h0000_3004, 1'b1, 4'h0); tick();
    chk("pg_miss_ras", {ras, cas}, {2'b00, 4'h0});
    tick(); tick();
    chk("pg_miss_pre", ras, 0);
    tick();
    chk("pg_miss_reopen", {ras, dram_addr}, {2'b01, 11'h001});
    idle_bus();
`else
    // Read of 0x0000_1004: bank 0, row 0, col 0x401.
    req(32'h0000_1004, 1'b1, 4'h0);
    tick();
    chk("rd_ras_t1", ras, 2'b01);
    chk("rd_row_t1", dram_addr, 0);
    chk("rd_ws_t1", waitstate, 1);
    chk("rd_cas_t1", cas, 0);
    tick();
    chk("rd_col_t2", dram_addr, 11'h401);
    chk("rd_cas_t2", cas, 0);
    chk("rd_ws_t2", waitstate, 1);
    tick();
    chk("rd_cas_t3", cas, 4'hf);
    chk("rd_ws_t3", waitstate, 0);
    chk("rd_we_t3", write, 0);
    idle_bus(); tick();
    chk("rd_end", {write, ras, cas, waitstate}, {1'b0, 2'b00, 4'h0, 1'b1});
    // Write to bank 1, row 1, col 2 presented during precharge.
    req(32'h0100_2008, 1'b0, 4'b0011);
    tick(); tick();
    chk("pre_ras_p3", ras, 0);
    tick();
    chk("wr_ras", ras, 2'b10);
    chk("wr_we", write, 1);
    chk("wr_row", dram_addr, 1);
    tick();
    chk("wr_col", dram_addr, 2);
    tick();
    chk("wr_cas", cas, 4'b0011);
    chk("wr_ws", waitstate, 0);
    idle_bus(); tick();
    chk("wr_end", {write, ras, cas, waitstate}, {1'b0, 2'b00, 4'h0, 1'b1});
    tick(); tick();
    // cs dropped while still in RAS-to-CAS delay.
    req(32'h0000_1004, 1'b1, 4'h0); tick();
    idle_bus(); tick(); tick();
    chk("early_cas", {cas, waitstate}, {4'hf, 1'b0});
    tick();
    chk("early_end", {ras, cas, waitstate}, {2'b00, 4'h0, 1'b1});
    tick(); tick(); tick();
    chk("early_idle", {ras, cas}, {2'b00, 4'h0});
`endif

    // Idle refresh cadence: refreshes at edges 252, 502, 752, 1002.
    idle_bus(); do_reset();
    prev_ras = 2'b00; prev_cas = 4'h0;
    nref = 0; first = 0; bad_order = 0; hi = 0;
    for (int k = 1; k <= 1010; k++) begin
      tick();
      if (ras == 2'b11) hi++;
      if (ras == 2'b11 && prev_ras != 2'b11) begin
        nref++;
        if (first == 0) first = k;
        if (!(prev_cas == 4'hf && prev_ras == 2'b00)) bad_order++;
      end
      prev_ras = ras; prev_cas = cas;
    end
    chk("ref_count", nref, 4);
    chk("ref_first", first, 252);
    chk("ref_order_bad", bad_order, 0);
    chk("ref_ras_cycles", hi, 8);

    // Backlog: hold an access over five intervals, then drain four refreshes.
    do_reset();
    req(32'h0000_1004, 1'b1, 4'h0);
    repeat (1300) tick();
    chk("backlog_pending", dut.w_pending, 4);
    chk("backlog_ras", ras, 2'b01);
    idle_bus(); tick();
    req(32'h0000_1004, 1'b1, 4'h0);
    prev_ras = ras; nref = 0; first = 0; first_acc = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (ras == 2'b11 && prev_ras != 2'b11 && first_acc == 0) begin
        nref++;
        if (first == 0) first = k;
      end
      if (ras == 2'b01 && first_acc == 0) first_acc = k;
      prev_ras = ras;
    end
    chk("backlog_refs", nref, 4);
    chk("backlog_first_ref", first, 5 + PG);
    chk("backlog_first_acc", first_acc, 28 + PG);
    chk("backlog_drained", dut.w_pending, 0);

    // Reset during REF_HOLD with one refresh still pending.
    idle_bus(); do_reset();
    req(32'h0000_1004, 1'b1, 4'h0);
    repeat (600) tick();
    idle_bus();
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ras == 2'b11) begin found = k; break; end
    end
    chk("rh_found", found, 5 + PG);
    tick();
    chk("rh_hold", {ras, cas}, {2'b11, 4'hf});
    reset_n = 1'b0;
    tick();
    chk("rh_abort", {write, ras, cas, waitstate}, {1'b0, 2'b00, 4'h0, 1'b1});
    chk("rh_pending", dut.w_pending, 0);
    chk("rh_addr", dram_addr, 0);
    reset_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (ras == 2'b11) begin first = k; break; end
    end
    chk("rh_restart", first, 252);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
